window_initiator: RTL and testbench

- Initiator side of the one-second window timer interface. This block issues the arm pulse, waits for the timer to report the window open, and scores the player's button press against that window.
- Produces the hit/miss result, the reaction time in ms, and a saturating hit tally for the display/score logic.
- Sits between the game FSM (start request) and the window timer (arm/clear out, status in).
- Same 1 kHz `clock` as the timer, so 1 cycle = 1 ms.

---
 rtl/window_initiator.sv | 166 ++++++++++++++++
 tb/tb_window_initiator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/window_initiator.sv
// Reaction-window initiator: arms the window timer, scores the button press, keeps a hit tally.
// Optional button debounce via `define WINDOW_INITIATOR_DEBOUNCE_EN.
module window_initiator #(
    parameter int unsigned ACK_TIMEOUT     = 8,
    parameter int unsigned MAX_MS          = 1023,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       on,
    input  logic       start,
    input  logic       button,
    input  logic       score_clear,
    input  logic       win_status,
    output logic       arm,
    output logic       win_clear,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic       miss,
    output logic       err,
    output logic [9:0] react_ms,
    output logic [7:0] hit_count
);
    localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_OPEN, OPEN, RESULT} state_t;

    state_t            state;
    logic              button_q;
    logic              button_q_prev;
    logic              btn_armed;
    logic              press;
    logic [WAIT_W-1:0] wait_cnt;
    logic [9:0]        react_cnt;
    logic              arm_r;
    logic              win_clear_r;
    logic              done_r;

    // Pulses are suppressed while the block is disabled; the registers simply hold.
    assign arm       = arm_r & on;
    assign win_clear = win_clear_r & on;
    assign done      = done_r & on;
    assign busy      = (state != IDLE);
    assign press     = button_q & ~button_q_prev & btn_armed;

`ifdef WINDOW_INITIATOR_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt;

    // button_q follows the raw button only after it has been stable at a new value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            button_q      <= 1'b0;
            button_q_prev <= 1'b0;
            db_cnt        <= '0;
        end else if (on) begin
            button_q_prev <= button_q;
            if (button == button_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                button_q <= button;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end
`else
    logic unused_db;
    assign unused_db = (DEBOUNCE_CYCLES == 0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            button_q      <= 1'b0;
            button_q_prev <= 1'b0;
        end else if (on) begin
            button_q      <= button;
            button_q_prev <= button_q;
        end
    end
`endif

    // Round sequencing, result capture and hit tally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            arm_r       <= 1'b0;
            win_clear_r <= 1'b0;
            done_r      <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            err         <= 1'b0;
            react_ms    <= '0;
            hit_count   <= '0;
            btn_armed   <= 1'b0;
            wait_cnt    <= '0;
            react_cnt   <= '0;
        end else if (on) begin
            arm_r       <= 1'b0;
            win_clear_r <= 1'b0;
            done_r      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        arm_r <= 1'b1;
                    end
                end
                ARM: begin
                    wait_cnt  <= '0;
                    react_cnt <= '0;
                    btn_armed <= ~button_q;
                    state     <= WAIT_OPEN;
                end
                WAIT_OPEN: begin
                    if (win_status) begin
                        state <= OPEN;
                    end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
                        state    <= RESULT;
                        done_r   <= 1'b1;
                        err      <= 1'b1;
                        hit      <= 1'b0;
                        miss     <= 1'b0;
                        react_ms <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                OPEN: begin
                    if (react_cnt != 10'(MAX_MS)) begin
                        react_cnt <= react_cnt + 10'd1;
                    end
                    if (!btn_armed && !button_q) begin
                        btn_armed <= 1'b1;
                    end
                    // Window closing outranks a simultaneous press.
                    if (!win_status) begin
                        state    <= RESULT;
                        done_r   <= 1'b1;
                        miss     <= 1'b1;
                        hit      <= 1'b0;
                        err      <= 1'b0;
                        react_ms <= '0;
                    end else if (press) begin
                        state       <= RESULT;
                        done_r      <= 1'b1;
                        win_clear_r <= 1'b1;
                        hit         <= 1'b1;
                        miss        <= 1'b0;
                        err         <= 1'b0;
                        react_ms    <= react_cnt;
                        if (hit_count != 8'hFF) begin
                            hit_count <= hit_count + 8'd1;
                        end
                    end
                end
                RESULT: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (score_clear) begin
                hit_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_window_initiator.sv
// Directed self-checking bench for window_initiator; expected values are hand-computed.
module tb_window_initiator;
`ifdef WINDOW_INITIATOR_DEBOUNCE_EN
    localparam int DB = 3;
`else
    localparam int DB = 0;
`endif

    logic       clock, reset, on, start, button, score_clear, win_status;
    logic       arm, win_clear, busy, done, hit, miss, err;
    logic [9:0] react_ms;
    logic [7:0] hit_count;

    int total = 0;
    int bad   = 0;
    bit got;
    int lost;

    window_initiator dut (
        .clock(clock), .reset(reset), .on(on), .start(start), .button(button),
        .score_clear(score_clear), .win_status(win_status), .arm(arm),
        .win_clear(win_clear), .busy(busy), .done(done), .hit(hit), .miss(miss),
        .err(err), .react_ms(react_ms), .hit_count(hit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_done(input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            tick(1);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    // Start a round; returns in the first OPEN cycle (react_cnt=0) when ws=1.
    task automatic begin_round(input logic ws);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        win_status = ws;
        tick(2);
    endtask

    task automatic do_hit(output bit seen);
        begin_round(1'b1);
        button = 1'b1;
        wait_done(10 + DB, seen);
        button = 1'b0;
        win_status = 1'b0;
        tick(DB + 3);
    endtask

    initial begin
        reset = 1'b0; on = 1'b1; start = 1'b0; button = 1'b0;
        score_clear = 1'b0; win_status = 1'b0;
        tick(2);
        check("reset_busy", busy, 0);
        check("reset_outs", {arm, win_clear, done, hit, miss, err}, 0);
        check("reset_count", hit_count, 0);
        reset = 1'b1;
        tick(2);

        // Basic hit at react 149
        start = 1'b1;
        tick(1);
        check("arm_pulse", arm, 1);
        check("busy_arm", busy, 1);
        start = 1'b0;
        tick(1);
        check("arm_one_cycle", arm, 0);
        win_status = 1'b1;
        tick(1);
        tick(148);
        button = 1'b1;
        wait_done(10 + DB, got);
        check("t1_done", got, 1);
        check("t1_hit", {hit, miss, err}, 3'b100);
        check("t1_react", react_ms, 149 + DB);
        check("t1_win_clear", win_clear, 1);
        check("t1_count", hit_count, 1);
        tick(1);
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);
        check("t1_hold", hit, 1);
        button = 1'b0;
        win_status = 1'b0;
        tick(DB + 3);

        // Miss: status held 1000 cycles, no press
        begin_round(1'b1);
        tick(1000);
        check("t2_no_done", done, 0);
        win_status = 1'b0;
        wait_done(3, got);
        check("t2_done", got, 1);
        check("t2_miss", {hit, miss, err}, 3'b010);
        check("t2_react", react_ms, 0);
        check("t2_no_clear", win_clear, 0);
        check("t2_count", hit_count, 1);
        tick(DB + 3);

        // Ack timeout: 8 waiting cycles then RESULT
        begin_round(1'b0);
        tick(6);
        check("t3_early", done, 0);
        tick(1);
        check("t3_done", done, 1);
        check("t3_err", {hit, miss, err}, 3'b001);
        check("t3_react", react_ms, 0);
        tick(1);
        check("t3_idle", busy, 0);

        // Button held through ARM; release then press
        button = 1'b1;
        tick(DB + 3);
        begin_round(1'b1);
        tick(10);
        check("t4_held_nohit", {done, busy}, 2'b01);
        button = 1'b0;
        tick(29);
        button = 1'b1;
        wait_done(10 + DB, got);
        check("t4_done", got, 1);
        check("t4_hit", hit, 1);
        check("t4_react", react_ms, 40 + DB);
        check("t4_count", hit_count, 2);
        button = 1'b0;
        win_status = 1'b0;
        tick(DB + 3);

        // on=0 for 20 cycles freezes react_cnt
        begin_round(1'b1);
        tick(10);
        on = 1'b0;
        tick(20);
        check("t5_hold_busy", busy, 1);
        check("t5_hold_pulses", {arm, win_clear, done}, 0);
        on = 1'b1;
        tick(18);
        button = 1'b1;
        wait_done(10 + DB, got);
        check("t5_done", got, 1);
        check("t5_react", react_ms, 29 + DB);
        check("t5_count", hit_count, 3);
        button = 1'b0;
        win_status = 1'b0;
        tick(DB + 3);

        // Saturation at 255
        lost = 0;
        for (int i = 0; i < 252; i++) begin
            do_hit(got);
            if (!got) lost++;
        end
        check("t6_all_hits", lost, 0);
        check("t6_count255", hit_count, 255);
        do_hit(got);
        check("t6_sat_done", got, 1);
        check("t6_saturated", hit_count, 255);

        // score_clear coinciding with a hit
        begin_round(1'b1);
        button = 1'b1;
        tick(1 + DB);
        score_clear = 1'b1;
        tick(1);
        check("t6_clr_done", done, 1);
        check("t6_clr_hit", hit, 1);
        check("t6_clr_count", hit_count, 0);
        score_clear = 1'b0;
        button = 1'b0;
        win_status = 1'b0;
        tick(DB + 3);
        do_hit(got);
        check("t7_pre_count", hit_count, 1);

        // Async reset mid-OPEN
        begin_round(1'b1);
        tick(5);
        check("t7_in_open", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_outs", {arm, win_clear, done, hit, miss, err}, 0);
        check("t7_rst_react", react_ms, 0);
        check("t7_rst_count", hit_count, 0);
        reset = 1'b1;
        win_status = 1'b0;
        tick(2);
        check("t7_after_idle", {busy, done, win_clear}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
